// File: rtl/error_converge_check.sv
// error_converge_check
//   Convergence test at the end of a FastICA iteration. A start request
//   snapshots 16 absolute errors, 16 candidate weights and a tolerance. The
//   errors are scanned one per cycle for the largest magnitude. That maximum
//   is compared against the tolerance to either commit the weights or
//   request another iteration, with a sticky timeout after MAX_ITER failures.
//
//   Ports
//     clk_conv     : clock, rising edge
//     rstn_conv    : asynchronous active-low reset
//     start_conv   : single-cycle start; i_abs/i_w_new/i_tol valid this cycle
//     i_tol        : tolerance, unsigned magnitude
//     i_abs        : N packed signed errors, element k at [k*DW +: DW]
//     i_w_new      : N packed candidate weights, same packing
//     o_busy       : high while a check is in progress
//     o_done       : one-cycle pulse when the decision is valid
//     o_converged  : decision result, held until the next done
//     o_timeout    : sticky, set once failed checks reach MAX_ITER
//     o_next_iter  : pulse with o_done when another iteration is wanted
//     o_iter       : failed checks since reset or last convergence
//     o_w_final    : committed weights
//     o_max_err    : (CONV_MAXIDX_EN) largest magnitude of the last check
//     o_max_idx    : (CONV_MAXIDX_EN) index of that magnitude
//
//   Optional feature macro: CONV_MAXIDX_EN adds o_max_err / o_max_idx.
module error_converge_check #(
   parameter int DW       = 26,
   parameter int N        = 16,
   parameter int MAX_ITER = 64,
   parameter int IW       = 7
) (
   input  logic            clk_conv,
   input  logic            rstn_conv,
   input  logic            start_conv,
   input  logic [DW-1:0]   i_tol,
   input  logic [N*DW-1:0] i_abs,
   input  logic [N*DW-1:0] i_w_new,
   output logic            o_busy,
   output logic            o_done,
   output logic            o_converged,
   output logic            o_timeout,
   output logic            o_next_iter,
   output logic [IW-1:0]   o_iter,
   output logic [N*DW-1:0] o_w_final
`ifdef CONV_MAXIDX_EN
   ,
   output logic [DW-1:0]   o_max_err,
   output logic [3:0]      o_max_idx
`endif
);

   localparam int XW = $clog2(N);
   localparam logic [XW-1:0] LAST_IDX   = XW'(N - 1);
   localparam logic [IW:0]   MAX_ITER_C = (IW+1)'(MAX_ITER);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SCAN   = 2'd1,
      S_DECIDE = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   // Magnitude of a signed element; the most negative code has no positive
   // counterpart in DW bits, so it saturates to the largest positive value.
   function automatic logic [DW-1:0] abs_mag(input logic [DW-1:0] e);
      logic [DW-1:0] min_neg;
      min_neg = {1'b1, {(DW-1){1'b0}}};
      if (!e[DW-1]) begin
         abs_mag = e;
      end else if (e == min_neg) begin
         abs_mag = {1'b0, {(DW-1){1'b1}}};
      end else begin
         abs_mag = (~e) + {{(DW-1){1'b0}}, 1'b1};
      end
   endfunction

   state_t          state_r, state_s;
   logic [N*DW-1:0] abs_sh_r, w_sh_r;
   logic [DW-1:0]   tol_sh_r;
   logic [XW-1:0]   idx_r;
   logic [DW-1:0]   max_r;
   logic [XW-1:0]   max_idx_r;
   logic            conv_r;
   logic [DW-1:0]   mag_s;
   logic            conv_s;
   logic [IW:0]     iter_inc_s;

   assign mag_s      = abs_mag(abs_sh_r[idx_r*DW +: DW]);
   assign conv_s     = (max_r < tol_sh_r);
   assign iter_inc_s = {1'b0, o_iter} + {{IW{1'b0}}, 1'b1};

   // State register.
   always_ff @(posedge clk_conv or negedge rstn_conv) begin
      if (!rstn_conv) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state decode; starts outside IDLE are simply not looked at.
   always_comb begin
      state_s = state_r;
      case (state_r)
         S_IDLE: begin
            if (start_conv) begin
               state_s = S_SCAN;
            end else begin
               state_s = S_IDLE;
            end
         end
         S_SCAN: begin
            if (idx_r == LAST_IDX) begin
               state_s = S_DECIDE;
            end else begin
               state_s = S_SCAN;
            end
         end
         S_DECIDE: state_s = S_DONE;
         S_DONE:   state_s = S_IDLE;
         default:  state_s = S_IDLE;
      endcase
   end

   // Shadow capture, serial max scan and the convergence decision.
   always_ff @(posedge clk_conv or negedge rstn_conv) begin
      if (!rstn_conv) begin
         abs_sh_r  <= {(N*DW){1'b0}};
         w_sh_r    <= {(N*DW){1'b0}};
         tol_sh_r  <= {DW{1'b0}};
         idx_r     <= {XW{1'b0}};
         max_r     <= {DW{1'b0}};
         max_idx_r <= {XW{1'b0}};
         conv_r    <= 1'b0;
         o_iter    <= {IW{1'b0}};
         o_timeout <= 1'b0;
         o_w_final <= {(N*DW){1'b0}};
`ifdef CONV_MAXIDX_EN
         o_max_err <= {DW{1'b0}};
         o_max_idx <= 4'd0;
`endif
      end else begin
         case (state_r)
            S_IDLE: begin
               if (start_conv) begin
                  abs_sh_r  <= i_abs;
                  w_sh_r    <= i_w_new;
                  tol_sh_r  <= i_tol;
                  idx_r     <= {XW{1'b0}};
                  max_r     <= {DW{1'b0}};
                  max_idx_r <= {XW{1'b0}};
               end
            end
            S_SCAN: begin
               // Strict compare keeps the lowest index on ties.
               if (mag_s > max_r) begin
                  max_r     <= mag_s;
                  max_idx_r <= idx_r;
               end
               idx_r <= idx_r + {{(XW-1){1'b0}}, 1'b1};
            end
            S_DECIDE: begin
               conv_r <= conv_s;
               if (conv_s) begin
                  o_w_final <= w_sh_r;
                  o_iter    <= {IW{1'b0}};
                  o_timeout <= 1'b0;
               end else begin
                  if (iter_inc_s <= MAX_ITER_C) begin
                     o_iter <= iter_inc_s[IW-1:0];
                  end
                  if (iter_inc_s >= MAX_ITER_C) begin
                     o_timeout <= 1'b1;
                  end
               end
`ifdef CONV_MAXIDX_EN
               o_max_err <= max_r;
               o_max_idx <= 4'(max_idx_r);
`endif
            end
            S_DONE: begin
            end
            default: begin
            end
         endcase
      end
   end

   // Handshake outputs, registered; o_timeout has already settled in DECIDE.
   always_ff @(posedge clk_conv or negedge rstn_conv) begin
      if (!rstn_conv) begin
         o_busy      <= 1'b0;
         o_done      <= 1'b0;
         o_converged <= 1'b0;
         o_next_iter <= 1'b0;
      end else begin
         o_busy      <= (state_s != S_IDLE);
         o_done      <= (state_r == S_DONE);
         o_next_iter <= (state_r == S_DONE) & ~conv_r & ~o_timeout;
         if (state_r == S_DONE) begin
            o_converged <= conv_r;
         end
      end
   end

endmodule
